// File: rtl/axis_stat_unpack.sv
// Unpacks a byte-serial statistics frame (tag, tick, byte, frame counts; MSB first)
// into a held parallel record, flagging short, long and tuser-marked frames.
module axis_stat_unpack #(
    parameter int TAG_ENABLE         = 1,
    parameter int TAG_WIDTH          = 16,
    parameter int TICK_COUNT_ENABLE  = 1,
    parameter int TICK_COUNT_WIDTH   = 32,
    parameter int BYTE_COUNT_ENABLE  = 1,
    parameter int BYTE_COUNT_WIDTH   = 32,
    parameter int FRAME_COUNT_ENABLE = 1,
    parameter int FRAME_COUNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tuser,
    output logic [TAG_WIDTH-1:0]         m_tag,
    output logic [TICK_COUNT_WIDTH-1:0]  m_tick_count,
    output logic [BYTE_COUNT_WIDTH-1:0]  m_byte_count,
    output logic [FRAME_COUNT_WIDTH-1:0] m_frame_count,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         error_length,
    output logic                         error_bad_frame,
    output logic                         busy
);

    localparam int TAG_EFF   = (TAG_ENABLE != 0)         ? TAG_WIDTH         : 0;
    localparam int TICK_EFF  = (TICK_COUNT_ENABLE != 0)  ? TICK_COUNT_WIDTH  : 0;
    localparam int BYTE_EFF  = (BYTE_COUNT_ENABLE != 0)  ? BYTE_COUNT_WIDTH  : 0;
    localparam int FRAME_EFF = (FRAME_COUNT_ENABLE != 0) ? FRAME_COUNT_WIDTH : 0;
    localparam int SR_W      = TAG_EFF + TICK_EFF + BYTE_EFF + FRAME_EFF;
    localparam int N         = SR_W / 8;
    localparam int PTR_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N - 1);

    // The last field on the wire lands in the least significant bits.
    localparam int FRAME_OFF = 0;
    localparam int BYTE_OFF  = FRAME_OFF + FRAME_EFF;
    localparam int TICK_OFF  = BYTE_OFF + BYTE_EFF;
    localparam int TAG_OFF   = TICK_OFF + TICK_EFF;

    localparam logic [0:0] RECV = 1'b0;
    localparam logic [0:0] DROP = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [SR_W-1:0] shift_q, shift_d;
    logic [SR_W-1:0] record_q, record_d;
    logic            valid_q, valid_d;
    logic            errLen_q, errLen_d;
    logic            errBad_q, errBad_d;
    logic            readyEn_q;
    logic            atLast;
    logic            accept;
    logic [SR_W-1:0] assembled;

    assign atLast    = (ptr_q == LAST_PTR);
    // Only the final byte has to wait for the held record to be consumed.
    assign s_axis_tready = readyEn_q &
                           ~((state_q == RECV) && atLast && valid_q && !m_ready);
    assign accept    = s_axis_tvalid & s_axis_tready;
    assign assembled = (shift_q << 8) | SR_W'(s_axis_tdata);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        shift_d  = shift_q;
        record_d = record_q;
        valid_d  = valid_q & ~m_ready;
        errLen_d = 1'b0;
        errBad_d = 1'b0;
        if (accept) begin
            if (state_q == DROP) begin
                if (s_axis_tlast) state_d = RECV;
            end else begin
                shift_d = assembled;
                if (!atLast) begin
                    if (s_axis_tlast) begin
                        errLen_d = 1'b1;
                        ptr_d    = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end else begin
                    ptr_d = '0;
                    if (!s_axis_tlast) begin
                        errLen_d = 1'b1;
                        state_d  = DROP;
                    end else if (s_axis_tuser) begin
                        errBad_d = 1'b1;
                    end else begin
                        record_d = assembled;
                        valid_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RECV;
            ptr_q     <= '0;
            shift_q   <= '0;
            record_q  <= '0;
            valid_q   <= 1'b0;
            errLen_q  <= 1'b0;
            errBad_q  <= 1'b0;
            readyEn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            shift_q   <= shift_d;
            record_q  <= record_d;
            valid_q   <= valid_d;
            errLen_q  <= errLen_d;
            errBad_q  <= errBad_d;
            readyEn_q <= 1'b1;
        end
    end

    assign m_valid         = valid_q;
    assign error_length    = errLen_q;
    assign error_bad_frame = errBad_q;
    assign busy            = (ptr_q != '0) || (state_q == DROP);

    generate
        if (TAG_ENABLE != 0) begin : gTag
            assign m_tag = record_q[TAG_OFF +: TAG_WIDTH];
        end else begin : gNoTag
            assign m_tag = '0;
        end
        if (TICK_COUNT_ENABLE != 0) begin : gTick
            assign m_tick_count = record_q[TICK_OFF +: TICK_COUNT_WIDTH];
        end else begin : gNoTick
            assign m_tick_count = '0;
        end
        if (BYTE_COUNT_ENABLE != 0) begin : gByte
            assign m_byte_count = record_q[BYTE_OFF +: BYTE_COUNT_WIDTH];
        end else begin : gNoByte
            assign m_byte_count = '0;
        end
        if (FRAME_COUNT_ENABLE != 0) begin : gFrame
            assign m_frame_count = record_q[FRAME_OFF +: FRAME_COUNT_WIDTH];
        end else begin : gNoFrame
            assign m_frame_count = '0;
        end
    endgenerate

endmodule
